alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl_pkg.sv | 41 ++++
 rtl/alarm_ctrl_bcd_time_add.sv | 37 +++
 rtl/alarm_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the alarm clock front-panel controller.
package alarm_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EDIT_TIME  = 3'd1,
        S_EDIT_ALARM = 3'd2,
        S_COMMIT     = 3'd3,
        S_RING       = 3'd4,
        S_SNZ_STOP   = 3'd5,
        S_SNZ_LOAD   = 3'd6,
        S_RESTORE    = 3'd7
    } state_t;

    // What follows the stop pulse issued from RING
    typedef enum logic [1:0] {
        STOP_SNOOZE  = 2'd0,
        STOP_RESTORE = 2'd1,
        STOP_IDLE    = 2'd2
    } stop_kind_t;

    // Edit digit indices
    localparam logic [1:0] DIG_H1 = 2'd0;
    localparam logic [1:0] DIG_H0 = 2'd1;
    localparam logic [1:0] DIG_M1 = 2'd2;
    localparam logic [1:0] DIG_M0 = 2'd3;

    // Largest legal value of each BCD digit
    localparam logic [3:0] H1_LIM    = 4'd2;
    localparam logic [3:0] H0_LIM    = 4'd9;
    localparam logic [3:0] H0_LIM_20 = 4'd3;  // H0 limit when H1 is 2
    localparam logic [3:0] M1_LIM    = 4'd5;
    localparam logic [3:0] M0_LIM    = 4'd9;

    // Increment a BCD digit, wrapping to 0 past its limit
    function automatic logic [3:0] digit_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_ctrl_bcd_time_add.sv
// Combinational hh:mm (BCD) plus 0..59 minutes, wrapping at 23:59.
module bcd_time_add (
    input  logic [1:0] h1_i,
    input  logic [3:0] h0_i,
    input  logic [3:0] m1_i,
    input  logic [3:0] m0_i,
    input  logic [5:0] add_min_i,
    output logic [1:0] h1_o,
    output logic [3:0] h0_o,
    output logic [3:0] m1_o,
    output logic [3:0] m0_o
);

    logic [6:0] min_bin;
    logic [6:0] min_sum;
    logic [6:0] min_wrap;
    logic [4:0] hr_bin;
    logic [4:0] hr_sum;
    logic [4:0] hr_wrap;
    logic       carry;

    // Convert to binary, add, wrap minutes and hours, convert back to BCD
    always_comb begin
        min_bin  = {3'b000, m1_i} * 7'd10 + {3'b000, m0_i};
        min_sum  = min_bin + {1'b0, add_min_i};
        carry    = (min_sum >= 7'd60);
        min_wrap = carry ? (min_sum - 7'd60) : min_sum;
        hr_bin   = {3'b000, h1_i} * 5'd10 + {1'b0, h0_i};
        hr_sum   = hr_bin + {4'b0000, carry};
        hr_wrap  = (hr_sum >= 5'd24) ? 5'd0 : hr_sum;
        m1_o     = 4'(min_wrap / 7'd10);
        m0_o     = 4'(min_wrap % 7'd10);
        h1_o     = 2'(hr_wrap / 5'd10);
        h0_o     = 4'(hr_wrap % 5'd10);
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Button-driven controller for an alarm clock: time/alarm editing, ring
// handling with bounded snooze, and load/stop pulses to the clock core.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int SNOOZE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       Alarm,
    input  logic [1:0] H_out1,
    input  logic [3:0] H_out0,
    input  logic [3:0] M_out1,
    input  logic [3:0] M_out0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       AL_ON,
    output logic       editing,
    output logic [1:0] edit_digit
);

    localparam logic [7:0] SNZ_MAX_C = 8'(SNOOZE_MAX);
    localparam logic [5:0] SNZ_MIN_C = 6'(SNOOZE_MIN);

    state_t     state_q, state_d;
    stop_kind_t stop_kind_q, stop_kind_d;
    logic [1:0] digit_q, digit_d;
    logic       tgt_alarm_q, tgt_alarm_d;
    logic [7:0] snz_cnt_q, snz_cnt_d;
    logic       al_on_q, al_on_d;
    // Edit registers
    logic [1:0] eh1_q, eh1_d;
    logic [3:0] eh0_q, eh0_d, em1_q, em1_d, em0_q, em0_d;
    // Stored user alarm
    logic [1:0] ah1_q, ah1_d;
    logic [3:0] ah0_q, ah0_d, am1_q, am1_d, am0_q, am0_d;
    // Last value presented on the load bus
    logic [1:0] oh1_q, ld_h1;
    logic [3:0] oh0_q, om1_q, om0_q, ld_h0, ld_m1, ld_m0;
    // Current time plus snooze length
    logic [1:0] sn_h1;
    logic [3:0] sn_h0, sn_m1, sn_m0;

    bcd_time_add u_snz_add (
        .h1_i      (H_out1),
        .h0_i      (H_out0),
        .m1_i      (M_out1),
        .m0_i      (M_out0),
        .add_min_i (SNZ_MIN_C),
        .h1_o      (sn_h1),
        .h0_o      (sn_h0),
        .m1_o      (sn_m1),
        .m0_o      (sn_m0)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            stop_kind_q <= STOP_IDLE;
            digit_q     <= 2'd0;
            tgt_alarm_q <= 1'b0;
            snz_cnt_q   <= 8'd0;
            al_on_q     <= 1'b0;
            eh1_q <= 2'd0; eh0_q <= 4'd0; em1_q <= 4'd0; em0_q <= 4'd0;
            ah1_q <= 2'd0; ah0_q <= 4'd0; am1_q <= 4'd0; am0_q <= 4'd0;
            oh1_q <= 2'd0; oh0_q <= 4'd0; om1_q <= 4'd0; om0_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            stop_kind_q <= stop_kind_d;
            digit_q     <= digit_d;
            tgt_alarm_q <= tgt_alarm_d;
            snz_cnt_q   <= snz_cnt_d;
            al_on_q     <= al_on_d;
            eh1_q <= eh1_d; eh0_q <= eh0_d; em1_q <= em1_d; em0_q <= em0_d;
            ah1_q <= ah1_d; ah0_q <= ah0_d; am1_q <= am1_d; am0_q <= am0_d;
            oh1_q <= ld_h1; oh0_q <= ld_h0; om1_q <= ld_m1; om0_q <= ld_m0;
        end
    end

    // Next-state, edit datapath and pulse outputs
    always_comb begin
        state_d     = state_q;
        stop_kind_d = stop_kind_q;
        digit_d     = digit_q;
        tgt_alarm_d = tgt_alarm_q;
        snz_cnt_d   = snz_cnt_q;
        al_on_d     = al_on_q;
        eh1_d = eh1_q; eh0_d = eh0_q; em1_d = em1_q; em0_d = em0_q;
        ah1_d = ah1_q; ah0_d = ah0_q; am1_d = am1_q; am0_d = am0_q;
        ld_h1 = oh1_q; ld_h0 = oh0_q; ld_m1 = om1_q; ld_m0 = om0_q;
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        STOP_al  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Alarm) begin
                    state_d = S_RING;
                end else if (btn_mode) begin
                    state_d = S_EDIT_TIME;
                    eh1_d = H_out1; eh0_d = H_out0; em1_d = M_out1; em0_d = M_out0;
                    digit_d = DIG_H1;
                end else if (btn_set) begin
                    al_on_d = ~al_on_q;
                end
            end

            S_EDIT_TIME, S_EDIT_ALARM: begin
                if (Alarm) begin
                    // Ringing takes over; the edit is dropped without a load
                    state_d = S_RING;
                end else if (btn_mode) begin
                    if (state_q == S_EDIT_TIME) begin
                        state_d = S_EDIT_ALARM;
                        eh1_d = ah1_q; eh0_d = ah0_q; em1_d = am1_q; em0_d = am0_q;
                        digit_d = DIG_H1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (btn_set) begin
                    if (digit_q == DIG_M0) begin
                        state_d     = S_COMMIT;
                        tgt_alarm_d = (state_q == S_EDIT_ALARM);
                    end else begin
                        digit_d = digit_q + 2'd1;
                    end
                end else if (btn_inc) begin
                    case (digit_q)
                        DIG_H1: begin
                            eh1_d = (eh1_q >= H1_LIM[1:0]) ? 2'd0 : eh1_q + 2'd1;
                            // Keep the hour legal when entering the 20s
                            if (eh1_d == 2'd2 && eh0_q > H0_LIM_20)
                                eh0_d = 4'd0;
                        end
                        DIG_H0: eh0_d = digit_inc(eh0_q, (eh1_q == 2'd2) ? H0_LIM_20 : H0_LIM);
                        DIG_M1: em1_d = digit_inc(em1_q, M1_LIM);
                        DIG_M0: em0_d = digit_inc(em0_q, M0_LIM);
                    endcase
                end
            end

            S_COMMIT: begin
                ld_h1 = eh1_q; ld_h0 = eh0_q; ld_m1 = em1_q; ld_m0 = em0_q;
                if (tgt_alarm_q) begin
                    LD_alarm = 1'b1;
                    ah1_d = eh1_q; ah0_d = eh0_q; am1_d = em1_q; am0_d = em0_q;
                end else begin
                    LD_time = 1'b1;
                end
                state_d = Alarm ? S_RING : S_IDLE;
            end

            S_RING: begin
                if (btn_set || (btn_snooze && snz_cnt_q >= SNZ_MAX_C)) begin
                    // Final stop: put the user alarm back if a snooze moved it
                    stop_kind_d = (snz_cnt_q != 8'd0) ? STOP_RESTORE : STOP_IDLE;
                    snz_cnt_d   = 8'd0;
                    state_d     = S_SNZ_STOP;
                end else if (btn_snooze) begin
                    stop_kind_d = STOP_SNOOZE;
                    snz_cnt_d   = snz_cnt_q + 8'd1;
                    state_d     = S_SNZ_STOP;
                end
            end

            S_SNZ_STOP: begin
                // Stop pulse shared by snooze and final stop
                STOP_al = 1'b1;
                case (stop_kind_q)
                    STOP_SNOOZE:  state_d = S_SNZ_LOAD;
                    STOP_RESTORE: state_d = S_RESTORE;
                    default:      state_d = S_IDLE;
                endcase
            end

            S_SNZ_LOAD: begin
                ld_h1 = sn_h1; ld_h0 = sn_h0; ld_m1 = sn_m1; ld_m0 = sn_m0;
                LD_alarm = 1'b1;
                state_d  = S_IDLE;
            end

            S_RESTORE: begin
                ld_h1 = ah1_q; ld_h0 = ah0_q; ld_m1 = am1_q; ld_m0 = am0_q;
                LD_alarm = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Digit pointer rests at H1 whenever no edit is in progress
        if (state_d != S_EDIT_TIME && state_d != S_EDIT_ALARM)
            digit_d = DIG_H1;
    end

    assign H_in1      = ld_h1;
    assign H_in0      = ld_h0;
    assign M_in1      = ld_m1;
    assign M_in0      = ld_m0;
    assign AL_ON      = al_on_q;
    assign editing    = (state_q == S_EDIT_TIME) || (state_q == S_EDIT_ALARM);
    assign edit_digit = digit_q;

endmodule
